// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states, default latencies.
// Optional macro MD_MSUB_EN turns op 7 into msub; otherwise op 7 is a no-op.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MADD  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_MSUB  = 3'd7;

    localparam int MD_MULT_LAT = 5;
    localparam int MD_DIV_LAT  = 10;
    localparam int MD_CNT_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    // Ops that occupy the unit for a latency count rather than writing HI/LO directly.
    function automatic logic is_multi(input logic [2:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD: is_multi = 1'b1;
`ifdef MD_MSUB_EN
            MD_MSUB: is_multi = 1'b1;
`else
            MD_MSUB: is_multi = 1'b0;
`endif
            default: is_multi = 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        is_div = (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational 64-bit {hi, lo} result for every MD op, including divide-by-zero and overflow rules.
// Optional macro MD_MSUB_EN enables the msub accumulate path for op 7.
module md_result_calc
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] acc;
    logic        signed_div;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;

    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'b0, rs} * {32'b0, rt};
    assign acc    = {hi, lo};

    // One unsigned divider serves both forms; signed div works on magnitudes and fixes signs after.
    // 0x80000000 / -1 yields magnitude 0x80000000 with positive sign, which is exactly the wrap result.
    assign signed_div = (op == MD_DIV);
    assign dvd = (signed_div && rs[31]) ? -rs : rs;
    assign dvs = (rt == 32'd0) ? 32'd1 : ((signed_div && rt[31]) ? -rt : rt);
    assign uq  = dvd / dvs;
    assign ur  = dvd % dvs;
    assign q   = (signed_div && (rs[31] ^ rt[31])) ? -uq : uq;
    assign r   = (signed_div && rs[31]) ? -ur : ur;

    always_comb begin
        result = acc;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV,
            MD_DIVU:  result = (rt == 32'd0) ? {rs, 32'hFFFF_FFFF} : {r, q};
            MD_MADD:  result = acc + prod_s;
`ifdef MD_MSUB_EN
            MD_MSUB:  result = acc - prod_s;
`else
            MD_MSUB:  result = acc;
`endif
            default:  result = acc;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, runs the fixed-latency busy counter and raises stall_req.
// Optional macro MD_MSUB_EN makes op 7 an msub handled like madd.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT,
    parameter int DIV_LAT  = MD_DIV_LAT,
    parameter int CNT_W    = MD_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_in_d,
    output logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output md_state_t   state
);

    md_state_t        state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_d;
    logic [31:0]      hi_d;
    logic [31:0]      lo_d;
    logic [63:0]      pend;
    logic [63:0]      pend_d;
    logic [63:0]      result;
    logic             idle_op;

    md_result_calc u_calc (
        .op     (op),
        .rs     (rs_val),
        .rt     (rt_val),
        .hi     (hi),
        .lo     (lo),
        .result (result)
    );

    assign idle_op   = op_valid && (state == IDLE);
    assign start     = idle_op && is_multi(op);
    assign stall_req = md_in_d && (start || busy);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        busy_d  = busy;
        hi_d    = hi;
        lo_d    = lo;
        pend_d  = pend;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    pend_d  = result;
                    cnt_d   = is_div(op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end else if (idle_op && op == MD_MTHI) begin
                    hi_d = rs_val;
                end else if (idle_op && op == MD_MTLO) begin
                    lo_d = rs_val;
                end
            end
            RUN: begin
                // op_valid is deliberately ignored here; the hazard unit keeps E clear while busy.
                if (cnt == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    hi_d    = pend[63:32];
                    lo_d    = pend[31:0];
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            pend  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            busy  <= busy_d;
            hi    <= hi_d;
            lo    <= lo_d;
            pend  <= pend_d;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed vector table, reset-abort sequence, randomized ops vs. a reference model.
module tb_md_sequencer;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        md_in_d = 1'b0;
    logic        start;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    md_state_t   state;

    int checks = 0;
    int failures = 0;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        mdd;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    md_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .md_in_d   (md_in_d),
        .start     (start),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .state     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) assert (!(busy && op_valid)) else $error("op_valid presented while busy");
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: arithmetic straight from the op definitions using native signed integers.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a_u, input logic [31:0] b_u,
                                          input logic [31:0] h, input logic [31:0] l);
        int     a;
        int     b;
        int     q;
        int     r;
        longint p;
        a = a_u;
        b = b_u;
        p = longint'(a) * longint'(b);
        case (o)
            3'd0: model = p;
            3'd1: model = {32'b0, a_u} * {32'b0, b_u};
            3'd2: begin
                if (b_u == 32'd0) model = {a_u, 32'hFFFF_FFFF};
                else if (a_u == 32'h8000_0000 && b_u == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
                else begin
                    q = a / b;
                    r = a % b;
                    model = {r, q};
                end
            end
            3'd3: model = (b_u == 32'd0) ? {a_u, 32'hFFFF_FFFF} : {a_u % b_u, a_u / b_u};
            3'd4: model = {h, l} + p;
            3'd5: model = {a_u, l};
            3'd6: model = {h, a_u};
`ifdef MD_MSUB_EN
            default: model = {h, l} - p;
`else
            default: model = {h, l};
`endif
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        case (o)
            3'd0, 3'd1, 3'd4: lat_of = 5;
            3'd2, 3'd3:       lat_of = 10;
`ifdef MD_MSUB_EN
            3'd7:             lat_of = 5;
`endif
            default:          lat_of = 0;
        endcase
    endfunction

    task automatic run_op(input vec_t v);
        int n;
        @(negedge clk);
        op_valid = 1'b1;
        op = v.op;
        rs_val = v.rs;
        rt_val = v.rt;
        md_in_d = v.mdd;
        #1;
        chk({v.name, " start"}, 64'(start), 64'(v.lat != 0));
        chk({v.name, " stall_start"}, 64'(stall_req), 64'(v.mdd && v.lat != 0));
        @(posedge clk);
        if (v.lat == 0) begin
            #1;
            chk({v.name, " busy"}, 64'(busy), 64'd0);
            chk({v.name, " hi"}, 64'(hi), 64'(v.exp_hi));
            chk({v.name, " lo"}, 64'(lo), 64'(v.exp_lo));
        end else begin
            @(negedge clk);
            op_valid = 1'b0;
            #1;
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                chk({v.name, " stall_busy"}, 64'(stall_req), 64'(v.mdd));
                n++;
                @(negedge clk);
                #1;
            end
            chk({v.name, " busy_cycles"}, 64'(n), 64'(v.lat));
            chk({v.name, " hi"}, 64'(hi), 64'(v.exp_hi));
            chk({v.name, " lo"}, 64'(lo), 64'(v.exp_lo));
            chk({v.name, " stall_after"}, 64'(stall_req), 64'd0);
            md_in_d = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        logic [63:0] e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset state", 64'(state), 64'(IDLE));
        chk("reset start", 64'(start), 64'd0);

        vecs.push_back('{"mult_neg",     3'd0, 32'hFFFF_FFFE, 32'd3,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
        vecs.push_back('{"divu_stall",   3'd3, 32'd100,       32'd7,         1'b1, 32'd2,         32'd14,        10});
        vecs.push_back('{"div_ovf",      3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h8000_0000, 10});
        vecs.push_back('{"div_zero",     3'd2, 32'd5,         32'd0,         1'b0, 32'd5,         32'hFFFF_FFFF, 10});
        vecs.push_back('{"mthi",         3'd5, 32'h1234,      32'd9,         1'b1, 32'h1234,      32'hFFFF_FFFF, 0});
        vecs.push_back('{"mtlo",         3'd6, 32'h5678,      32'd9,         1'b0, 32'h1234,      32'h5678,      0});
        vecs.push_back('{"madd",         3'd4, 32'd2,         32'd3,         1'b1, 32'h1234,      32'h567E,      5});
        vecs.push_back('{"multu_max",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 5});
        vecs.push_back('{"div_neg",      3'd2, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        vecs.push_back('{"divu_zero",    3'd3, 32'hFFFF_FFF9, 32'd0,         1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 10});
        vecs.push_back('{"mthi_0",       3'd5, 32'd0,         32'd0,         1'b0, 32'd0,         32'hFFFF_FFFF, 0});
        vecs.push_back('{"mtlo_10",      3'd6, 32'd10,        32'd0,         1'b0, 32'd0,         32'd10,        0});
`ifdef MD_MSUB_EN
        vecs.push_back('{"msub",         3'd7, 32'd2,         32'd3,         1'b0, 32'd0,         32'd4,         5});
`else
        vecs.push_back('{"op7_nop",      3'd7, 32'd2,         32'd3,         1'b1, 32'd0,         32'd10,        0});
`endif

        foreach (vecs[i]) run_op(vecs[i]);
        @(negedge clk);
        op_valid = 1'b0;

        // Reset during the third busy cycle of a mult aborts it and clears HI/LO.
        @(negedge clk);
        op_valid = 1'b1;
        op = 3'd0;
        rs_val = 32'd7;
        rt_val = 32'd9;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        chk("abort state", 64'(state), 64'(IDLE));
        repeat (8) @(negedge clk);
        #1;
        chk("abort no_late_commit", {hi, lo}, 64'd0);
        hi_m = '0;
        lo_m = '0;
        v = '{"mult_after_abort", 3'd0, 32'd7, 32'd9, 1'b1, 32'd0, 32'd63, 5};
        run_op(v);
        hi_m = 32'd0;
        lo_m = 32'd63;

        // Randomized ops against the reference model.
        for (int k = 0; k < 40; k++) begin
            v.name = "rand";
            v.op = 3'($urandom_range(0, 7));
            v.rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            v.rt = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 7) == 0) v.rt = 32'd0;
            if ($urandom_range(0, 15) == 0) begin
                v.rs = 32'h8000_0000;
                v.rt = 32'hFFFF_FFFF;
            end
            v.mdd = 1'($urandom_range(0, 1));
            e = model(v.op, v.rs, v.rt, hi_m, lo_m);
            v.exp_hi = e[63:32];
            v.exp_lo = e[31:0];
            v.lat = lat_of(v.op);
            run_op(v);
            hi_m = e[63:32];
            lo_m = e[31:0];
        end
        @(negedge clk);
        op_valid = 1'b0;
        md_in_d = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
